memory_stage: RTL and testbench

- Pipeline stage directly downstream of the execution stage.
- Consumes the registered execution outputs: control bits, destination register, store data and ALU result/address.
- Performs data-memory loads and stores over a variable-latency req/ack port and stalls the upstream pipeline while an access is pending.
- Drives registered write-back signals for the register file.

---
 rtl/memory_stage_pkg.sv | 21 ++
 rtl/memory_stage_if.sv | 34 +++
 rtl/mem_access_fsm.sv | 92 +++++++++
 rtl/stage_register.sv | 20 ++
 rtl/memory_stage.sv | 105 ++++++++++
 tb/tb_memory_stage.sv | 201 ++++++++++++++++++++
 6 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
// Defines the FSM state type, default widths and the access-needed rule.
package memory_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  localparam int DATA_W_DEF = 24;
  localparam int ADDR_W_DEF = 16;
  localparam int REG_IDX_W  = 4;

  // Loads are register writes whose value does not come from the ALU.
  function automatic logic needs_access(input logic mem_we,
                                        input logic reg_we,
                                        input logic write_from_alu);
    return mem_we | (reg_we & ~write_from_alu);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
interface memory_stage_if
  import memory_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              memReq;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;
  logic              memAck;

  modport master (
    output memReq,
    output memWrite,
    output memAddr,
    output memWdata,
    input  memRdata,
    input  memAck
  );

  modport slave (
    input  memReq,
    input  memWrite,
    input  memAddr,
    input  memWdata,
    output memRdata,
    output memAck
  );

endinterface

// File: rtl/mem_access_fsm.sv
// Memory access sequencer: captures the instruction, drives the req/ack bus,
// bounds the wait with a timeout and produces the upstream stall.
module mem_access_fsm
  import memory_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memWe,
  input  logic                 regWe,
  input  logic                 writeRegFromAlu,
  input  logic [REG_IDX_W-1:0] regToWrite,
  input  logic [DATA_W-1:0]    dataToWrite,
  input  logic [DATA_W-1:0]    aluResult,
  memory_stage_if.master       mem,
  output logic                 stall,
  output logic                 idle,
  output logic                 complete,
  output logic                 memError,
  output logic                 hold_reg_we,
  output logic                 hold_from_alu,
  output logic [REG_IDX_W-1:0] hold_idx,
  output logic [DATA_W-1:0]    hold_alu
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] count;
  logic             access;
  logic             at_limit;

  assign access   = needs_access(memWe, regWe, writeRegFromAlu);
  assign at_limit = (count == LAST);
  assign idle     = (state == IDLE);
  assign complete = (state == BUSY) && mem.memAck;

  // A timeout releases the stall in its final cycle, so the dropped instruction is not replayed.
  assign stall = idle ? access : (!mem.memAck && !at_limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      mem.memReq    <= 1'b0;
      mem.memWrite  <= 1'b0;
      mem.memAddr   <= '0;
      mem.memWdata  <= '0;
      memError      <= 1'b0;
      hold_reg_we   <= 1'b0;
      hold_from_alu <= 1'b0;
      hold_idx      <= '0;
      hold_alu      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            hold_reg_we   <= regWe;
            hold_from_alu <= writeRegFromAlu;
            hold_idx      <= regToWrite;
            hold_alu      <= aluResult;
            mem.memReq    <= 1'b1;
            mem.memWrite  <= memWe;
            mem.memAddr   <= aluResult[ADDR_W-1:0];
            mem.memWdata  <= dataToWrite;
            count         <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          // An ack in the limit cycle still completes the access.
          if (mem.memAck) begin
            mem.memReq <= 1'b0;
            state      <= IDLE;
          end else if (at_limit) begin
            mem.memReq <= 1'b0;
            memError   <= 1'b1;
            state      <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stage_register.sv
// Generic pipeline register with synchronous active-high reset and load enable.
module stage_register #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: sequences data-memory accesses and registers
// the write-back enable, index and value for the register file.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memWe,
  input  logic                 regWe,
  input  logic                 writeRegFromAlu,
  input  logic [REG_IDX_W-1:0] regToWrite,
  input  logic [DATA_W-1:0]    dataToWrite,
  input  logic [DATA_W-1:0]    aluResult,
  memory_stage_if.master       mem,
  output logic                 stall,
  output logic                 wbRegWe,
  output logic [REG_IDX_W-1:0] wbRegToWrite,
  output logic [DATA_W-1:0]    wbData,
  output logic                 memError
);

  logic                 idle;
  logic                 complete;
  logic                 access;
  logic                 hold_reg_we;
  logic                 hold_from_alu;
  logic [REG_IDX_W-1:0] hold_idx;
  logic [DATA_W-1:0]    hold_alu;
  logic                 wb_load;
  logic                 wb_we_next;
  logic [REG_IDX_W-1:0] wb_idx_next;
  logic [DATA_W-1:0]    wb_data_next;

  assign access = needs_access(memWe, regWe, writeRegFromAlu);

  mem_access_fsm #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk             (clk),
    .reset           (reset),
    .memWe           (memWe),
    .regWe           (regWe),
    .writeRegFromAlu (writeRegFromAlu),
    .regToWrite      (regToWrite),
    .dataToWrite     (dataToWrite),
    .aluResult       (aluResult),
    .mem             (mem),
    .stall           (stall),
    .idle            (idle),
    .complete        (complete),
    .memError        (memError),
    .hold_reg_we     (hold_reg_we),
    .hold_from_alu   (hold_from_alu),
    .hold_idx        (hold_idx),
    .hold_alu        (hold_alu)
  );

  // Write-back enable defaults to a bubble; index and data only load when a result retires.
  always_comb begin
    wb_load      = 1'b0;
    wb_we_next   = 1'b0;
    wb_idx_next  = regToWrite;
    wb_data_next = aluResult;
    if (idle && !access) begin
      wb_load    = 1'b1;
      wb_we_next = regWe;
    end else if (complete) begin
      wb_load      = 1'b1;
      wb_we_next   = hold_reg_we;
      wb_idx_next  = hold_idx;
      wb_data_next = hold_from_alu ? hold_alu : mem.memRdata;
    end
  end

  stage_register #(.WIDTH(1)) u_wb_we (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (wb_we_next),
    .q     (wbRegWe)
  );

  stage_register #(.WIDTH(REG_IDX_W)) u_wb_idx (
    .clk   (clk),
    .reset (reset),
    .en    (wb_load),
    .d     (wb_idx_next),
    .q     (wbRegToWrite)
  );

  stage_register #(.WIDTH(DATA_W)) u_wb_data (
    .clk   (clk),
    .reset (reset),
    .en    (wb_load),
    .d     (wb_data_next),
    .q     (wbData)
  );

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed plan steps followed by random
// instructions, checked against an instruction-level reference model.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memWe;
  logic        regWe;
  logic        writeRegFromAlu;
  logic [3:0]  regToWrite;
  logic [23:0] dataToWrite;
  logic [23:0] aluResult;
  logic        stall;
  logic        wbRegWe;
  logic [3:0]  wbRegToWrite;
  logic [23:0] wbData;
  logic        memError;

  int   checks = 0;
  int   errors = 0;
  logic err_seen = 1'b0;

  memory_stage_if #(.DATA_W(24), .ADDR_W(16)) mem_bus ();

  memory_stage #(.DATA_W(24), .ADDR_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .memWe           (memWe),
    .regWe           (regWe),
    .writeRegFromAlu (writeRegFromAlu),
    .regToWrite      (regToWrite),
    .dataToWrite     (dataToWrite),
    .aluResult       (aluResult),
    .mem             (mem_bus),
    .stall           (stall),
    .wbRegWe         (wbRegWe),
    .wbRegToWrite    (wbRegToWrite),
    .wbData          (wbData),
    .memError        (memError)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic mw, input logic rw, input logic fa,
                               input logic [3:0] idx, input logic [23:0] wdat,
                               input logic [23:0] alu);
    memWe           = mw;
    regWe           = rw;
    writeRegFromAlu = fa;
    regToWrite      = idx;
    dataToWrite     = wdat;
    aluResult       = alu;
  endtask

  // One instruction from the first cycle it is presented until the negedge after it retires.
  // ack_delay = BUSY cycles without ack before the ack cycle; >= TIMEOUT means no ack.
  task automatic runInstr(input string tag, input logic mw, input logic rw, input logic fa,
                          input logic [3:0] idx, input logic [23:0] wdat,
                          input logic [23:0] alu, input logic [23:0] rdat,
                          input int ack_delay);
    logic acc, timed_out, saw_stall, finished, bus_ok, exp_we;
    int   exp_cycles, stall_cnt, req_cnt;
    logic [23:0] exp_data;

    acc        = mw | (rw & ~fa);
    timed_out  = acc && (ack_delay >= TIMEOUT);
    exp_cycles = !acc ? 0 : (timed_out ? TIMEOUT : ack_delay + 1);
    exp_we     = rw & ~timed_out;
    exp_data   = (rw & ~fa) ? rdat : alu;

    applyStimulus(mw, rw, fa, idx, wdat, alu);
    stall_cnt = 0;
    req_cnt   = 0;
    finished  = 1'b0;
    bus_ok    = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (mem_bus.memReq) mem_bus.memAck = (req_cnt == ack_delay);
      else                mem_bus.memAck = 1'($urandom_range(0, 1));
      mem_bus.memRdata = (mem_bus.memReq && mem_bus.memAck) ? rdat : 24'($urandom);
      #1;
      if (cyc > 0) checkOutput({tag, "_wb_bubble"}, 32'(wbRegWe), 32'd0);
      if (mem_bus.memReq) begin
        req_cnt++;
        if (mem_bus.memAddr !== alu[15:0] || mem_bus.memWrite !== mw ||
            (mw && mem_bus.memWdata !== wdat)) bus_ok = 1'b0;
      end
      if (stall) stall_cnt++;
      saw_stall = stall;
      @(negedge clk);
      if (!saw_stall) begin
        finished = 1'b1;
        break;
      end
    end
    mem_bus.memAck = 1'b0;
    if (timed_out) err_seen = 1'b1;

    checkOutput({tag, "_retired"}, 32'(finished), 32'd1);
    checkOutput({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_cycles));
    checkOutput({tag, "_req_cycles"}, 32'(req_cnt), 32'(exp_cycles));
    checkOutput({tag, "_bus_fields"}, 32'(bus_ok), 32'd1);
    checkOutput({tag, "_req_low"}, 32'(mem_bus.memReq), 32'd0);
    checkOutput({tag, "_mem_error"}, 32'(memError), 32'(err_seen));
    checkOutput({tag, "_wb_we"}, 32'(wbRegWe), 32'(exp_we));
    if (exp_we) begin
      checkOutput({tag, "_wb_idx"}, 32'(wbRegToWrite), 32'(idx));
      checkOutput({tag, "_wb_data"}, 32'(wbData), 32'(exp_data));
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0);
    mem_bus.memAck   = 1'b0;
    mem_bus.memRdata = 24'd0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req", 32'(mem_bus.memReq), 32'd0);
    checkOutput("rst_wb_we", 32'(wbRegWe), 32'd0);
    checkOutput("rst_wb_idx", 32'(wbRegToWrite), 32'd0);
    checkOutput("rst_wb_data", 32'(wbData), 32'd0);
    checkOutput("rst_addr", 32'(mem_bus.memAddr), 32'd0);
    checkOutput("rst_err", 32'(memError), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    runInstr("alu_op", 1'b0, 1'b1, 1'b1, 4'd5, 24'h0, 24'h00ABCD, 24'h0, 0);
    runInstr("load_d3", 1'b0, 1'b1, 1'b0, 4'd3, 24'h0, 24'h000040, 24'h123456, 3);
    runInstr("store_d0", 1'b1, 1'b0, 1'b1, 4'd0, 24'hFEDCBA, 24'h000010, 24'h0, 0);
    runInstr("b2b_load", 1'b0, 1'b1, 1'b0, 4'd6, 24'h0, 24'h000022, 24'h0A0B0C, 1);
    runInstr("b2b_alu", 1'b0, 1'b1, 1'b1, 4'd7, 24'h0, 24'h777777, 24'h0, 0);
    runInstr("ack_at_limit", 1'b0, 1'b1, 1'b0, 4'd2, 24'h0, 24'h000050, 24'h55AA55, TIMEOUT - 1);
    runInstr("timeout", 1'b0, 1'b1, 1'b0, 4'd8, 24'h0, 24'h000080, 24'h111111, 99);
    runInstr("post_timeout_alu", 1'b0, 1'b1, 1'b1, 4'd9, 24'h0, 24'h00BEEF, 24'h0, 0);

    // Reset during the second BUSY cycle of a load, followed by a late ack.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd9, 24'h0, 24'h000123);
    mem_bus.memAck = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rstb_req_busy", 32'(mem_bus.memReq), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    err_seen = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0);
    #1;
    checkOutput("rstb_req", 32'(mem_bus.memReq), 32'd0);
    checkOutput("rstb_err", 32'(memError), 32'd0);
    checkOutput("rstb_wb_we", 32'(wbRegWe), 32'd0);
    checkOutput("rstb_wb_idx", 32'(wbRegToWrite), 32'd0);
    checkOutput("rstb_wb_data", 32'(wbData), 32'd0);
    checkOutput("rstb_stall", 32'(stall), 32'd0);
    mem_bus.memAck   = 1'b1;
    mem_bus.memRdata = 24'h000BAD;
    @(negedge clk);
    mem_bus.memAck = 1'b0;
    #1;
    checkOutput("late_ack_req", 32'(mem_bus.memReq), 32'd0);
    checkOutput("late_ack_wb_we", 32'(wbRegWe), 32'd0);
    checkOutput("late_ack_wb_data", 32'(wbData), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      int          kind;
      logic        mw, rw, fa;
      logic [3:0]  idx;
      logic [23:0] wdat, alu, rdat;
      kind = $urandom_range(0, 3);
      idx  = 4'($urandom);
      wdat = 24'($urandom);
      alu  = 24'($urandom);
      rdat = 24'($urandom);
      case (kind)
        0:       begin mw = 1'b0; rw = 1'($urandom_range(0, 1)); fa = 1'b1; end
        1:       begin mw = 1'b0; rw = 1'b1; fa = 1'b0; end
        2:       begin mw = 1'b1; rw = 1'($urandom_range(0, 1)); fa = 1'b1; end
        default: begin mw = 1'b0; rw = 1'b0; fa = 1'b0; end
      endcase
      runInstr($sformatf("rnd%0d", i), mw, rw, fa, idx, wdat, alu, rdat,
               int'($urandom_range(0, TIMEOUT + 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
